lmu_measacc: RTL and testbench

LMU_MEASACC -- requirements
Module: lmu_measacc

---
 rtl/lmu_measacc.sv | 171 +++++++++++++++++
 tb/tb_lmu_measacc.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lmu_measacc.sv
`default_nettype none
// ============================================================================
// Module      : lmu_measacc
// Description : Measurement accumulator for logical qubits. Holds NUM_BANK
//               round banks of NUM_LQ parity bits. Accumulate ports XOR
//               measurement bits into the current write bank. acc_close hands
//               that bank to the reader, which reads single bits and then
//               releases (zeroes) the oldest closed bank. A separate register
//               holds the final-measurement value and valid flag for each
//               qubit.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               acc_valid/addr/bit    - per-port XOR accumulate requests
//               acc_close, acc_ready  - close write bank / write bank free
//               rd_req/addr, rd_data(_valid) - registered read, oldest bank
//               rd_release, rd_avail  - free oldest bank / closed bank exists
//               fin_wren/addr/val, fin_clr/clr_addr - final-measurement regs
//               finmeas_val/valid     - per-qubit final result and valid
//               overflow              - sticky: traffic dropped while FULL
// Revision    : 1.0 - initial release
// ============================================================================
module lmu_measacc #(
    parameter int NUM_LQ     = 16,
    parameter int LQADDR_BW  = 4,
    parameter int NUM_WRPORT = 2,
    parameter int NUM_BANK   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_WRPORT-1:0]           acc_valid,
    input  logic [NUM_WRPORT*LQADDR_BW-1:0] acc_addr,
    input  logic [NUM_WRPORT-1:0]           acc_bit,
    input  logic                            acc_close,
    output logic                            acc_ready,
    input  logic                            rd_req,
    input  logic [LQADDR_BW-1:0]            rd_addr,
    output logic                            rd_data,
    output logic                            rd_data_valid,
    input  logic                            rd_release,
    output logic                            rd_avail,
    input  logic                            fin_wren,
    input  logic [LQADDR_BW-1:0]            fin_addr,
    input  logic                            fin_val,
    input  logic                            fin_clr,
    input  logic [LQADDR_BW-1:0]            fin_clr_addr,
    output logic [NUM_LQ-1:0]               finmeas_val,
    output logic [NUM_LQ-1:0]               finmeas_valid,
    output logic                            overflow
);

    localparam int PTR_BW = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
    localparam int CNT_BW = $clog2(NUM_BANK + 1);
    localparam logic [CNT_BW-1:0] C_CNT_FULL = CNT_BW'(NUM_BANK);

    logic [NUM_LQ-1:0] r_bank [NUM_BANK];
    logic [PTR_BW-1:0] r_wr_ptr;
    logic [PTR_BW-1:0] r_rd_ptr;
    logic [CNT_BW-1:0] r_cnt;
    logic              r_rd_data;
    logic              r_rd_data_valid;
    logic [NUM_LQ-1:0] r_fin_val;
    logic [NUM_LQ-1:0] r_fin_valid;
    logic              r_overflow;

    logic              w_full;
    logic              w_empty;
    logic              w_do_close;
    logic              w_do_rel;
    logic              w_do_rd;
    logic [NUM_LQ-1:0] w_acc_mask;
    logic [NUM_LQ-1:0] w_rd_word;
    logic              w_rd_bit;

    // Bank occupancy is the only state; EMPTY/PARTIAL/FULL fall out of cnt.
    // FULL/EMPTY are taken from the current count, so a release in FULL does
    // not make room for a close in the same cycle.
    assign w_full     = (r_cnt == C_CNT_FULL);
    assign w_empty    = (r_cnt == '0);
    assign w_do_close = acc_close && !w_full;
    assign w_do_rel   = rd_release && !w_empty;
    assign w_do_rd    = rd_req && !w_empty;

    // Fold all ports into one toggle mask: ports hitting the same register
    // cancel pairwise, and out-of-range addresses match no register.
    always_comb begin
        w_acc_mask = '0;
        for (int p = 0; p < NUM_WRPORT; p++) begin
            for (int q = 0; q < NUM_LQ; q++) begin
                if (acc_valid[p] && (acc_addr[p*LQADDR_BW +: LQADDR_BW] == LQADDR_BW'(q)))
                    w_acc_mask[q] = w_acc_mask[q] ^ acc_bit[p];
            end
        end
    end

    // Bit select through a compare loop so rd_addr >= NUM_LQ reads 0.
    always_comb begin
        w_rd_word = r_bank[r_rd_ptr];
        w_rd_bit  = 1'b0;
        for (int q = 0; q < NUM_LQ; q++) begin
            if (rd_addr == LQADDR_BW'(q))
                w_rd_bit = w_rd_word[q];
        end
    end

    // In PARTIAL wr_ptr never equals rd_ptr, and in FULL accumulates are
    // dropped, so a release and an accumulate never target the same bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANK; b++)
                r_bank[b] <= '0;
        end else begin
            for (int b = 0; b < NUM_BANK; b++) begin
                if (w_do_rel && (r_rd_ptr == PTR_BW'(b)))
                    r_bank[b] <= '0;
                else if (!w_full && (r_wr_ptr == PTR_BW'(b)))
                    r_bank[b] <= r_bank[b] ^ w_acc_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_cnt           <= '0;
            r_rd_data       <= 1'b0;
            r_rd_data_valid <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            if (w_do_close)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rel)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_close && !w_do_rel)
                r_cnt <= r_cnt + 1'b1;
            else if (w_do_rel && !w_do_close)
                r_cnt <= r_cnt - 1'b1;
            // Read samples the bank before any same-cycle release clears it.
            r_rd_data_valid <= w_do_rd;
            r_rd_data       <= w_do_rd ? w_rd_bit : 1'b0;
            if (w_full && ((|acc_valid) || acc_close))
                r_overflow <= 1'b1;
        end
    end

    // Final-measurement registers; a write beats a clear on the same entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fin_val   <= '0;
            r_fin_valid <= '0;
        end else begin
            for (int q = 0; q < NUM_LQ; q++) begin
                if (fin_wren && (fin_addr == LQADDR_BW'(q))) begin
                    r_fin_valid[q] <= 1'b1;
                    r_fin_val[q]   <= fin_val;
                end else if (fin_clr && (fin_clr_addr == LQADDR_BW'(q))) begin
                    r_fin_valid[q] <= 1'b0;
                end
            end
        end
    end

    assign acc_ready     = !w_full;
    assign rd_avail      = !w_empty;
    assign rd_data       = r_rd_data;
    assign rd_data_valid = r_rd_data_valid;
    assign finmeas_val   = r_fin_val;
    assign finmeas_valid = r_fin_valid;
    assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_lmu_measacc.sv
`default_nettype none
// ============================================================================
// Module      : tb_lmu_measacc
// Description : Directed self-checking bench for lmu_measacc (default
//               parameters: 16 registers, 2 ports, 2 banks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lmu_measacc;

    logic        clk;
    logic        rst;
    logic [1:0]  acc_valid;
    logic [7:0]  acc_addr;
    logic [1:0]  acc_bit;
    logic        acc_close;
    logic        acc_ready;
    logic        rd_req;
    logic [3:0]  rd_addr;
    logic        rd_data;
    logic        rd_data_valid;
    logic        rd_release;
    logic        rd_avail;
    logic        fin_wren;
    logic [3:0]  fin_addr;
    logic        fin_val;
    logic        fin_clr;
    logic [3:0]  fin_clr_addr;
    logic [15:0] finmeas_val;
    logic [15:0] finmeas_valid;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    lmu_measacc #(
        .NUM_LQ     (16),
        .LQADDR_BW  (4),
        .NUM_WRPORT (2),
        .NUM_BANK   (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .acc_valid     (acc_valid),
        .acc_addr      (acc_addr),
        .acc_bit       (acc_bit),
        .acc_close     (acc_close),
        .acc_ready     (acc_ready),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .rd_release    (rd_release),
        .rd_avail      (rd_avail),
        .fin_wren      (fin_wren),
        .fin_addr      (fin_addr),
        .fin_val       (fin_val),
        .fin_clr       (fin_clr),
        .fin_clr_addr  (fin_clr_addr),
        .finmeas_val   (finmeas_val),
        .finmeas_valid (finmeas_valid),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle 1 ns so outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        acc_valid    = '0;
        acc_addr     = '0;
        acc_bit      = '0;
        acc_close    = 1'b0;
        rd_req       = 1'b0;
        rd_addr      = '0;
        rd_release   = 1'b0;
        fin_wren     = 1'b0;
        fin_addr     = '0;
        fin_val      = 1'b0;
        fin_clr      = 1'b0;
        fin_clr_addr = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_acc_ready", acc_ready, 1);
        chk("rst_rd_avail", rd_avail, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rd_valid", rd_data_valid, 0);
        chk("rst_fin_valid", finmeas_valid, 0);

        // Two ports on different registers, then both ports on register 3
        acc_valid = 2'b11; acc_addr = {4'd9, 4'd7}; acc_bit = 2'b01;
        tick();
        acc_addr = {4'd3, 4'd3}; acc_bit = 2'b11;
        tick();
        idle(); acc_close = 1'b1;
        tick();
        idle();
        chk("close1_rd_avail", rd_avail, 1);
        chk("close1_acc_ready", acc_ready, 1);
        rd_req = 1'b1; rd_addr = 4'd3;
        tick();
        chk("same_addr_valid", rd_data_valid, 1);
        chk("same_addr_data", rd_data, 0);
        rd_addr = 4'd7;
        tick();
        chk("port0_addr7", rd_data, 1);
        rd_addr = 4'd9;
        tick();
        chk("port1_bit0_addr9", rd_data, 0);
        idle(); rd_release = 1'b1;
        tick();
        idle();
        chk("rel1_rd_valid_low", rd_data_valid, 0);
        chk("rel1_rd_avail", rd_avail, 0);

        // Read request while EMPTY
        rd_req = 1'b1; rd_addr = 4'd7;
        tick();
        idle();
        chk("empty_rd_valid", rd_data_valid, 0);
        chk("empty_rd_data", rd_data, 0);

        // Accumulate coinciding with close lands in the closing bank
        acc_valid = 2'b01; acc_addr = {4'd0, 4'd2}; acc_bit = 2'b01; acc_close = 1'b1;
        tick();
        idle();
        chk("accclose_rd_avail", rd_avail, 1);
        // Read and release together return the pre-release contents
        rd_req = 1'b1; rd_addr = 4'd2; rd_release = 1'b1;
        tick();
        idle();
        chk("accclose_addr2", rd_data, 1);
        chk("accclose_valid", rd_data_valid, 1);
        chk("accclose_rel_empty", rd_avail, 0);
        acc_close = 1'b1;
        tick();
        idle();
        rd_req = 1'b1; rd_addr = 4'd2; rd_release = 1'b1;
        tick();
        idle();
        chk("newbank_addr2", rd_data, 0);

        // Fill both banks, then overflow
        acc_valid = 2'b01; acc_addr = {4'd0, 4'd4}; acc_bit = 2'b01; acc_close = 1'b1;
        tick();
        acc_addr = {4'd0, 4'd6};
        tick();
        idle();
        chk("full_acc_ready", acc_ready, 0);
        chk("full_rd_avail", rd_avail, 1);
        chk("full_no_overflow", overflow, 0);
        acc_valid = 2'b01; acc_addr = {4'd0, 4'd4}; acc_bit = 2'b01; acc_close = 1'b1;
        tick();
        idle();
        chk("drop_overflow", overflow, 1);
        chk("drop_acc_ready", acc_ready, 0);
        rd_req = 1'b1; rd_addr = 4'd4;
        tick();
        idle();
        chk("drop_bank_unchanged", rd_data, 1);

        // FULL: release and close together
        rd_release = 1'b1; acc_close = 1'b1;
        tick();
        idle();
        chk("relclose_acc_ready", acc_ready, 1);
        chk("relclose_rd_avail", rd_avail, 1);
        chk("relclose_overflow", overflow, 1);
        rd_req = 1'b1; rd_addr = 4'd6; rd_release = 1'b1;
        tick();
        idle();
        chk("relclose_second_bank", rd_data, 1);
        chk("relclose_now_empty", rd_avail, 0);
        acc_close = 1'b1;
        tick();
        idle();
        rd_req = 1'b1; rd_addr = 4'd4;
        tick();
        idle();
        chk("wrap_released_zero", rd_data, 0);
        chk("wrap_valid", rd_data_valid, 1);

        // Final-measurement write beats clear on the same entry
        fin_wren = 1'b1; fin_addr = 4'd5; fin_val = 1'b1; fin_clr = 1'b1; fin_clr_addr = 4'd5;
        tick();
        idle();
        chk("fin_valid_set", finmeas_valid, 16'h0020);
        chk("fin_val_set", finmeas_val, 16'h0020);
        fin_clr = 1'b1; fin_clr_addr = 4'd5;
        tick();
        idle();
        chk("fin_valid_clr", finmeas_valid, 16'h0000);
        chk("fin_val_kept", finmeas_val, 16'h0020);
        fin_wren = 1'b1; fin_addr = 4'd9; fin_val = 1'b0;
        tick();
        idle();
        chk("fin_valid9", finmeas_valid, 16'h0200);

        // Reset mid-operation: one closed bank pending, overflow set
        chk("pre_rst_rd_avail", rd_avail, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_rd_avail", rd_avail, 0);
        chk("midrst_acc_ready", acc_ready, 1);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_fin_valid", finmeas_valid, 0);
        chk("midrst_fin_val", finmeas_val, 0);
        acc_close = 1'b1;
        tick();
        idle();
        rd_req = 1'b1; rd_addr = 4'd6;
        tick();
        idle();
        chk("midrst_bank_zero", rd_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
